// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// MemAccessUnit (module mem_access_unit)
//
// Purpose:
//    CPU-side initiator for the data-memory port of the shared, latency-
//    modelled memory. Takes one load or store from the MEM stage, issues it
//    to memory as a one-cycle strobe, waits out the fixed memory latency,
//    captures load data from the bidirectional bus and reports completion
//    with a one-cycle cpu_ready pulse. Only one transaction is in flight at
//    a time; the pipeline stalls while mau_busy is high.
//
// Ports:
//    clk         system clock, all state changes on the rising edge
//    reset       synchronous, active-high reset
//    cpu_req     request from the pipeline, held until cpu_ready
//    cpu_we      1 = store, 0 = load
//    cpu_addr    word address
//    cpu_wdata   store data
//    cpu_rdata   registered load data, held after the ready pulse
//    cpu_ready   one-cycle completion pulse
//    mau_busy    high while a transaction occupies the unit
//    d_readM     memory read strobe
//    d_writeM    memory write strobe
//    d_address   memory address
//    d_data      bidirectional memory data bus
//
// Optional build macro:
//    MAU_STATS_EN  adds saturating 16-bit counters stat_reads, stat_writes
//                  and stat_stall as extra outputs.
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 2,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 mau_busy,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
`ifdef MAU_STATS_EN
    output logic [15:0]          stat_reads,
    output logic [15:0]          stat_writes,
    output logic [15:0]          stat_stall,
`endif
    inout  wire  [WORD_SIZE-1:0] d_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                 r_state;
    state_t                 w_nextState;

    logic                   r_we;
    logic [WORD_SIZE-1:0]   r_addr;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic [CNT_W-1:0]       r_count;
    logic [WORD_SIZE-1:0]   r_rdata;
    logic                   r_ready;
    logic                   w_driveData;

    // State register. Reset drops any transaction in flight without ever
    // producing a ready pulse, since the memory is reset on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and memory-side outputs. The strobes are only ever raised
    // in ISSUE: the memory restarts its latency count on any edge that sees
    // a strobe, so leaving one up into WAIT would corrupt the access.
    always_comb begin
        w_nextState = r_state;
        d_readM     = 1'b0;
        d_writeM    = 1'b0;
        d_address   = '0;
        w_driveData = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_nextState = S_ISSUE;
                end
            end
            S_ISSUE: begin
                d_readM     = ~r_we;
                d_writeM    = r_we;
                d_address   = r_addr;
                w_driveData = r_we;
                w_nextState = S_WAIT;
            end
            S_WAIT: begin
                if (r_count == CNT_ONE) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // The bus is ours only for the single ISSUE cycle of a store; every
    // other cycle it is released so the memory can return load data.
    assign d_data = w_driveData ? r_wdata : {WORD_SIZE{1'bz}};

    // Request capture, latency counter and response registers. The request
    // is frozen in IDLE so later changes on the CPU inputs cannot leak into
    // the access. The counter is only loaded in ISSUE and stops at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= (r_state == S_RESP);
            if (r_state == S_IDLE && cpu_req) begin
                r_we    <= cpu_we;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end
            if (r_state == S_ISSUE) begin
                r_count <= LAT_LOAD;
            end else if (r_state == S_WAIT && r_count != '0) begin
                r_count <= r_count - CNT_ONE;
            end
            if (r_state == S_RESP && !r_we) begin
                r_rdata <= d_data;
            end
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign mau_busy  = (r_state != S_IDLE);

`ifdef MAU_STATS_EN
    logic [15:0] r_statReads;
    logic [15:0] r_statWrites;
    logic [15:0] r_statStall;

    // Activity counters. A completion is the RESP edge; stall cycles are
    // every edge seen while busy. All three stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_statReads  <= '0;
            r_statWrites <= '0;
            r_statStall  <= '0;
        end else begin
            if (r_state == S_RESP && !r_we && r_statReads != 16'hFFFF) begin
                r_statReads <= r_statReads + 16'd1;
            end
            if (r_state == S_RESP && r_we && r_statWrites != 16'hFFFF) begin
                r_statWrites <= r_statWrites + 16'd1;
            end
            if (r_state != S_IDLE && r_statStall != 16'hFFFF) begin
                r_statStall <= r_statStall + 16'd1;
            end
        end
    end

    assign stat_reads  = r_statReads;
    assign stat_writes = r_statWrites;
    assign stat_stall  = r_statStall;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// Testbench for mem_access_unit.
//
// Contains a small latency-modelled memory on the d_* port. Each directed
// access pushes its hand-computed expected response into a scoreboard queue;
// a monitor running on the falling edge pops and compares whenever the unit
// raises cpu_ready, and checks every memory strobe against the head entry.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int LATENCY = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpuReq;
    logic        cpuWe;
    logic [15:0] cpuAddr;
    logic [15:0] cpuWdata;
    logic [15:0] cpuRdata;
    logic        cpuReady;
    logic        mauBusy;
    logic        dReadM;
    logic        dWriteM;
    logic [15:0] dAddress;
    wire  [15:0] dData;
`ifdef MAU_STATS_EN
    logic [15:0] statReads;
    logic [15:0] statWrites;
    logic [15:0] statStall;
`endif

    int errors = 0;
    int checks = 0;
    int cycleCount = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expRdata;
        int          expCycle;
    } txn_t;

    txn_t sbQueue[$];

    mem_access_unit #(
        .WORD_SIZE(16),
        .LATENCY  (LATENCY),
        .CNT_W    (2)
    ) dut (
        .clk        (clock),
        .reset      (reset),
        .cpu_req    (cpuReq),
        .cpu_we     (cpuWe),
        .cpu_addr   (cpuAddr),
        .cpu_wdata  (cpuWdata),
        .cpu_rdata  (cpuRdata),
        .cpu_ready  (cpuReady),
        .mau_busy   (mauBusy),
        .d_readM    (dReadM),
        .d_writeM   (dWriteM),
        .d_address  (dAddress),
`ifdef MAU_STATS_EN
        .stat_reads (statReads),
        .stat_writes(statWrites),
        .stat_stall (statStall),
`endif
        .d_data     (dData)
    );

    // Free-running clock and a cycle counter used for latency checks.
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cycleCount++;
    end

    // Memory model: captures on any edge with a strobe, then drives load data
    // for the single cycle after its latency has elapsed. Contents reload on
    // reset so every run starts from the same image.
    logic [15:0] memArray [0:255];
    int          memCnt    = 0;
    logic        memIsRead = 1'b0;
    logic [7:0]  memAddr   = 8'd0;
    logic        memDrive  = 1'b0;

    assign dData = memDrive ? memArray[memAddr] : 16'hzzzz;

    always @(posedge clock) begin
        memDrive <= 1'b0;
        if (reset) begin
            memCnt    <= 0;
            memIsRead <= 1'b0;
            memAddr   <= 8'd0;
            for (int i = 0; i < 256; i++) begin
                memArray[i] <= 16'h0000;
            end
            memArray[8'h01] <= 16'h0001;
            memArray[8'h02] <= 16'hFFFF;
            memArray[8'h23] <= 16'h6000;
        end else if (dReadM || dWriteM) begin
            memCnt    <= LATENCY;
            memIsRead <= dReadM;
            memAddr   <= dAddress[7:0];
            if (dWriteM) begin
                memArray[dAddress[7:0]] <= dData;
            end
        end else if (memCnt != 0) begin
            memCnt <= memCnt - 1;
            if (memCnt == 1 && memIsRead) begin
                memDrive <= 1'b1;
            end
        end
    end

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: checks strobes against the outstanding request and pops the
    // scoreboard on each ready pulse, also verifying latency, a single memory
    // capture and exactly four busy cycles per access.
    int strobeCnt = 0;
    int busyCnt   = 0;

    always @(negedge clock) begin
        txn_t t;
        if (reset) begin
            strobeCnt = 0;
            busyCnt   = 0;
        end else begin
            if (mauBusy) begin
                busyCnt++;
            end
            if (dReadM || dWriteM) begin
                strobeCnt++;
                if (sbQueue.size() == 0) begin
                    checkOutput("strobe_without_request", 32'd1, 32'd0);
                end else begin
                    checkOutput("strobe_is_write", {31'd0, dWriteM}, {31'd0, sbQueue[0].we});
                    checkOutput("strobe_is_read", {31'd0, dReadM}, {31'd0, ~sbQueue[0].we});
                    checkOutput("strobe_address", {16'd0, dAddress}, {16'd0, sbQueue[0].addr});
                    if (dWriteM) begin
                        checkOutput("store_bus_data", {16'd0, dData}, {16'd0, sbQueue[0].wdata});
                    end
                end
            end
            if (cpuReady) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("ready_without_request", 32'd1, 32'd0);
                end else begin
                    t = sbQueue.pop_front();
                    checkOutput("cpu_rdata", {16'd0, cpuRdata}, {16'd0, t.expRdata});
                    checkOutput("ready_cycle", cycleCount, t.expCycle);
                    checkOutput("captures_per_access", strobeCnt, 32'd1);
                    checkOutput("busy_cycles", busyCnt, 32'd4);
                    checkOutput("busy_in_ready_cycle", {31'd0, mauBusy}, 32'd0);
                end
                strobeCnt = 0;
                busyCnt   = 0;
            end
        end
    end

    // Drives one access at a falling edge and waits (bounded) for its ready
    // pulse. Consecutive calls are back-to-back: cpu_req stays high across
    // the ready cycle. Optionally changes cpu_addr while the access waits.
    task automatic applyStimulus(input logic we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] expRdata,
                                 input bit doLate, input logic [15:0] lateAddr);
        int waited;
        txn_t t;
        cpuWe    = we;
        cpuAddr  = addr;
        cpuWdata = wdata;
        cpuReq   = 1'b1;
        t.we       = we;
        t.addr     = addr;
        t.wdata    = wdata;
        t.expRdata = expRdata;
        t.expCycle = cycleCount + 5;
        sbQueue.push_back(t);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
            if (doLate && waited == 2) begin
                cpuAddr  = lateAddr;
                cpuWdata = ~wdata;
                cpuWe    = ~we;
            end
        end while (!cpuReady && waited < 20);
        checkOutput("ready_seen", {31'd0, cpuReady}, 32'd1);
        if (!cpuReady) begin
            sbQueue.delete();
        end
        cpuReq = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_d_readM"}, {31'd0, dReadM}, 32'd0);
        checkOutput({tag, "_d_writeM"}, {31'd0, dWriteM}, 32'd0);
        checkOutput({tag, "_d_address"}, {16'd0, dAddress}, 32'd0);
        checkOutput({tag, "_cpu_ready"}, {31'd0, cpuReady}, 32'd0);
        checkOutput({tag, "_cpu_rdata"}, {16'd0, cpuRdata}, 32'd0);
        checkOutput({tag, "_mau_busy"}, {31'd0, mauBusy}, 32'd0);
    endtask

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        reset    = 1'b1;
        cpuReq   = 1'b0;
        cpuWe    = 1'b0;
        cpuAddr  = 16'h0000;
        cpuWdata = 16'h0000;
        idleCycles(3);
        checkResetOutputs("reset");
        reset = 1'b0;
        idleCycles(1);

        applyStimulus(1'b0, 16'h0002, 16'h0000, 16'hFFFF, 1'b0, 16'h0000);
        idleCycles(2);

        applyStimulus(1'b1, 16'h00F0, 16'hABCD, 16'hFFFF, 1'b0, 16'h0000);
        idleCycles(2);
        applyStimulus(1'b0, 16'h00F0, 16'h0000, 16'hABCD, 1'b0, 16'h0000);
        idleCycles(2);

        applyStimulus(1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0023, 16'h0000, 16'h6000, 1'b0, 16'h0000);
        idleCycles(2);

        applyStimulus(1'b0, 16'h0002, 16'h0000, 16'hFFFF, 1'b1, 16'h0001);
        idleCycles(2);

        begin
            txn_t t;
            cpuWe    = 1'b0;
            cpuAddr  = 16'h0001;
            cpuWdata = 16'h0000;
            cpuReq   = 1'b1;
            t.we       = 1'b0;
            t.addr     = 16'h0001;
            t.wdata    = 16'h0000;
            t.expRdata = 16'h0001;
            t.expCycle = cycleCount + 5;
            sbQueue.push_back(t);
            idleCycles(2);
            checkOutput("abort_in_wait_busy", {31'd0, mauBusy}, 32'd1);
            reset  = 1'b1;
            cpuReq = 1'b0;
            idleCycles(1);
            checkResetOutputs("abort");
            sbQueue.delete();
            reset = 1'b0;
            for (int i = 0; i < 6; i++) begin
                idleCycles(1);
                checkOutput("abort_no_ready", {31'd0, cpuReady}, 32'd0);
            end
        end

        applyStimulus(1'b0, 16'h0001, 16'h0000, 16'h0001, 1'b0, 16'h0000);
        idleCycles(1);
        applyStimulus(1'b1, 16'h0005, 16'h1234, 16'h0001, 1'b0, 16'h0000);
        idleCycles(1);
        applyStimulus(1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 16'h0000);
        idleCycles(1);
        applyStimulus(1'b1, 16'h0006, 16'h5A5A, 16'h1234, 1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0006, 16'h0000, 16'h5A5A, 1'b0, 16'h0000);
        idleCycles(3);

`ifdef MAU_STATS_EN
        checkOutput("stat_reads", {16'd0, statReads}, 32'd3);
        checkOutput("stat_writes", {16'd0, statWrites}, 32'd2);
        checkOutput("stat_stall", {16'd0, statStall}, 32'd20);
`endif

        checkOutput("scoreboard_drained", sbQueue.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
